// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the Gigatron RAM slot arbiter.
// Optional loader-halt support is enabled by defining RAM_ARB_LOADER_HALT_EN.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2,
        OWN_LD   = 2'd3
    } owner_e;

    localparam int AW_DEFAULT = 16;
    localparam int SLOT_CPU   = 0;

    // Request/grant bit positions inside the round-robin picker.
    localparam int RR_VID = 0;
    localparam int RR_LD  = 1;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker for the shared slots (bit 0 = video, bit 1 = loader).
// The pointer only flips when both sides contend in an advancing slot.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       pointer
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        if (advance) begin
            if (&req) begin
                grant[ptr_q] = 1'b1;
                ptr_d        = ~ptr_q;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'(RR_VID);
        else        ptr_q <= ptr_d;
    end

    assign pointer = ptr_q;

endmodule

// File: rtl/ram_slot_arbiter.sv
// Pixel-clock time-slot scheduler for the single-port RAM: slot 0 belongs to the CPU,
// remaining slots are shared by video and loader. Define RAM_ARB_LOADER_HALT_EN for loader halt.
module ram_slot_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int SLOTS = 4
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          CORE_CE,
    input  logic [AW-1:0] CPU_A,
    input  logic [7:0]    CPU_WD,
    input  logic          CPU_WE,
    output logic [7:0]    CPU_RD,
    input  logic          VID_REQ,
    input  logic [AW-1:0] VID_A,
    output logic          VID_GNT,
    output logic          VID_RVALID,
    output logic [7:0]    VID_RD,
    input  logic          LD_REQ,
    input  logic [AW-1:0] LD_A,
    input  logic [7:0]    LD_WD,
    input  logic          LD_WE,
    input  logic          LD_HALT,
    output logic          LD_GNT,
    output logic          LD_RVALID,
    output logic [7:0]    LD_RD,
    output logic [AW-1:0] MEM_A,
    output logic [7:0]    MEM_WD,
    output logic          MEM_WE,
    input  logic [7:0]    MEM_RD
);

    localparam int            CW   = $clog2(SLOTS);
    localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          live_q;
    logic          core_ce_q, core_ce_d;
    logic [AW-1:0] mem_a_q;
    logic [7:0]    mem_wd_q;
    owner_e        sel, own_q, own_d;
    logic [7:0]    cpu_rd_q, cpu_rd_d;
    logic [7:0]    vid_rd_q, vid_rd_d;
    logic [7:0]    ld_rd_q, ld_rd_d;
    logic          halt, cpu_slot, shared;
    logic [1:0]    rr_grant;
    logic          unused_rr_ptr;

`ifdef RAM_ARB_LOADER_HALT_EN
    assign halt = LD_HALT;
`else
    logic unused_ld_halt;
    assign unused_ld_halt = LD_HALT;
    assign halt           = 1'b0;
`endif

    // live_q keeps the combinational MEM_* path quiet while reset is held
    // and in the first cycle after release.
    assign cpu_slot = live_q && (cnt_q == CW'(SLOT_CPU)) && !halt;
    assign shared   = live_q && !cpu_slot;

    ram_arb_rr u_rr (
        .clk     (CLK),
        .rst_n   (RST),
        .req     ({LD_REQ, VID_REQ}),
        .advance (shared),
        .grant   (rr_grant),
        .pointer (unused_rr_ptr)
    );

    always_comb begin
        sel = OWN_IDLE;
        if (cpu_slot)              sel = OWN_CPU;
        else if (rr_grant[RR_VID]) sel = OWN_VID;
        else if (rr_grant[RR_LD])  sel = OWN_LD;
    end

    // Idle slots keep MEM_A/MEM_WD at their last value.
    always_comb begin
        MEM_A  = mem_a_q;
        MEM_WD = mem_wd_q;
        MEM_WE = 1'b0;
        case (sel)
            OWN_CPU: begin
                MEM_A  = CPU_A;
                MEM_WD = CPU_WD;
                MEM_WE = CPU_WE;
            end
            OWN_VID: MEM_A = VID_A;
            OWN_LD: begin
                MEM_A  = LD_A;
                MEM_WD = LD_WD;
                MEM_WE = LD_WE;
            end
            default: ;
        endcase
    end

    // Owner tag follows the access by one cycle, lining up with MEM_RD; writes tag as idle.
    always_comb begin
        own_d = OWN_IDLE;
        if ((sel == OWN_VID) ||
            ((sel == OWN_CPU) && !CPU_WE) ||
            ((sel == OWN_LD) && !LD_WE))
            own_d = sel;
    end

    always_comb begin
        cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        core_ce_d = (cnt_d == LAST) && !halt;
        cpu_rd_d  = (own_q == OWN_CPU) ? MEM_RD : cpu_rd_q;
        vid_rd_d  = (own_q == OWN_VID) ? MEM_RD : vid_rd_q;
        ld_rd_d   = (own_q == OWN_LD)  ? MEM_RD : ld_rd_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q     <= '0;
            live_q    <= 1'b0;
            core_ce_q <= 1'b0;
            mem_a_q   <= '0;
            mem_wd_q  <= '0;
            own_q     <= OWN_IDLE;
            cpu_rd_q  <= '0;
            vid_rd_q  <= '0;
            ld_rd_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            live_q    <= 1'b1;
            core_ce_q <= core_ce_d;
            mem_a_q   <= MEM_A;
            mem_wd_q  <= MEM_WD;
            own_q     <= own_d;
            cpu_rd_q  <= cpu_rd_d;
            vid_rd_q  <= vid_rd_d;
            ld_rd_q   <= ld_rd_d;
        end
    end

    // A late LD_HALT still kills an already-registered pulse.
    assign CORE_CE    = core_ce_q && !halt;
    assign CPU_RD     = cpu_rd_q;
    assign VID_GNT    = (sel == OWN_VID);
    assign LD_GNT     = (sel == OWN_LD);
    assign VID_RVALID = (own_q == OWN_VID);
    assign LD_RVALID  = (own_q == OWN_LD);
    assign VID_RD     = vid_rd_d;
    assign LD_RD      = ld_rd_d;

endmodule
